// File: rtl/cla_add_pipe.sv
// cla_add_pipe: valid/ready pipelined adder built from 16-bit carry-lookahead groups split over STAGES slices.
// Define CLA_ADD_PIPE_SAT_EN to saturate s to the signed range on overflow.
module cla_add_pipe #(
  parameter int WIDTH = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int NG = WIDTH / 16;
  localparam int GPS = (NG + STAGES - 1) / STAGES;
  function automatic logic [15:0] cla16(input logic [15:0] g, input logic [15:0] p, input logic c0);
    logic [15:0] r;
    logic gg, pp;
    for (int i = 0; i < 16; i++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < i; j++) begin
        gg = g[j] | (p[j] & gg);
        pp = pp & p[j];
      end
      r[i] = p[i] ^ (gg | (pp & c0));
    end
    return r;
  endfunction
  // Adds groups [g0,g1) of x+y into acc; each group carry is a lookahead over the slice's group P/G.
  function automatic logic [WIDTH:0] add_slice(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] acc, input logic c0,
                                               input int g0, input int g1);
    logic [WIDTH-1:0] r;
    logic [NG-1:0] gg_v, pg_v;
    logic [15:0] gb, pb;
    logic gg, pp;
    r = acc;
    for (int j = 0; j < NG; j++) begin
      gb = x[16*j +: 16] & y[16*j +: 16];
      pb = x[16*j +: 16] ^ y[16*j +: 16];
      gg = 1'b0;
      for (int i = 0; i < 16; i++) gg = gb[i] | (pb[i] & gg);
      gg_v[j] = gg;
      pg_v[j] = &pb;
    end
    for (int j = g0; j < g1; j++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int i = g0; i < j; i++) begin
        gg = gg_v[i] | (pg_v[i] & gg);
        pp = pp & pg_v[i];
      end
      r[16*j +: 16] = cla16(x[16*j +: 16] & y[16*j +: 16], x[16*j +: 16] ^ y[16*j +: 16], gg | (pp & c0));
    end
    gg = 1'b0;
    pp = 1'b1;
    for (int i = g0; i < g1; i++) begin
      gg = gg_v[i] | (pg_v[i] & gg);
      pp = pp & pg_v[i];
    end
    return {gg | (pp & c0), r};
  endfunction
  logic stall;
  logic v_d [STAGES];
  logic c_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign v_d[0] = in_valid & in_ready;
  assign c_d[0] = ci;
  assign a_d[0] = a;
  assign b_d[0] = b;
  assign s_d[0] = '0;
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_st
    localparam int G0 = k * GPS;
    localparam int G1 = (k + 1) * GPS > NG ? NG : (k + 1) * GPS;
    logic [WIDTH:0] nxt;
    assign nxt = add_slice(a_d[k], b_d[k], s_d[k], c_d[k], G0, G1);
    if (k < STAGES - 1) begin : g_reg
      logic v_q, c_q;
      logic [WIDTH-1:0] a_q, b_q, s_q;
      always_ff @(posedge clk)
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
        end else if (!stall) begin
          v_q <= v_d[k];
          if (v_d[k]) begin
            c_q <= nxt[WIDTH];
            s_q <= nxt[WIDTH-1:0];
            a_q <= a_d[k];
            b_q <= b_d[k];
          end
        end
      assign v_d[k+1] = v_q;
      assign c_d[k+1] = c_q;
      assign a_d[k+1] = a_q;
      assign b_d[k+1] = b_q;
      assign s_d[k+1] = s_q;
    end else begin : g_reg
      logic ov;
      logic [WIDTH-1:0] sn;
      assign ov = (a_d[k][WIDTH-1] == b_d[k][WIDTH-1]) && (nxt[WIDTH-1] != a_d[k][WIDTH-1]);
`ifdef CLA_ADD_PIPE_SAT_EN
      assign sn = ov ? {a_d[k][WIDTH-1], {(WIDTH-1){~a_d[k][WIDTH-1]}}} : nxt[WIDTH-1:0];
`else
      assign sn = nxt[WIDTH-1:0];
`endif
      always_ff @(posedge clk)
        if (rst) begin
          out_valid <= 1'b0;
          s <= '0;
          co <= 1'b0;
          ovf <= 1'b0;
        end else if (!stall) begin
          out_valid <= v_d[k];
          if (v_d[k]) begin
            s <= sn;
            co <= nxt[WIDTH];
            ovf <= ov;
          end
        end
    end
  end
endmodule

// File: tb/tb_cla_add_pipe.sv
// tb_cla_add_pipe: directed vectors on a 32/2 instance plus random traffic on 64/3 and 64/1, all scoreboarded.
module tb_cla_add_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [2:0] done = '0;
  always #5 clk = ~clk;
  typedef struct packed {
    logic [127:0] s;
    logic co;
    logic ovf;
    logic [31:0] cyc;
    logic [31:0] st;
  } ent_t;
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask
  function automatic logic [129:0] model(input int w, input logic [127:0] x, input logic [127:0] y, input logic c);
    logic [128:0] full;
    logic [127:0] m, sum;
    logic cy, ov;
    m = w == 128 ? '1 : (128'd1 << w) - 128'd1;
    full = {1'b0, x & m} + {1'b0, y & m} + {128'd0, c};
    cy = full[w];
    sum = full[127:0] & m;
    ov = (x[w-1] == y[w-1]) && (sum[w-1] != x[w-1]);
`ifdef CLA_ADD_PIPE_SAT_EN
    if (ov) sum = x[w-1] ? (128'd1 << (w-1)) : (128'd1 << (w-1)) - 128'd1;
`endif
    return {sum, cy, ov};
  endfunction
  for (genvar i = 0; i < 3; i++) begin : g_d
    localparam int W = i == 0 ? 32 : 64;
    localparam int S = i == 0 ? 2 : (i == 1 ? 3 : 1);
    logic in_valid = 1'b0, ci = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, co, ovf;
    logic [W-1:0] a = '0, b = '0, s;
    ent_t q[$];
    ent_t e;
    logic [31:0] cyc = 0, st = 0;
    logic prev_stall = 1'b0;
    logic [W+2:0] prev = '0;
    logic [129:0] m;
    cla_add_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .ci(ci),
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf));
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk($sformatf("hold%0d", i), {out_valid, co, ovf, s}, prev);
        chk($sformatf("in_ready%0d", i), in_ready, !(out_valid && !out_ready));
        if (out_valid && out_ready) begin
          chk($sformatf("beat_expected%0d", i), q.size() > 0, 1'b1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("result%0d", i), {co, ovf, s}, {e.co, e.ovf, e.s[W-1:0]});
            chk($sformatf("latency%0d", i), cyc - e.cyc, S + st - e.st);
          end
        end
        prev_stall = out_valid && !out_ready;
        if (prev_stall) st++;
        prev = {out_valid, co, ovf, s};
        if (in_valid && in_ready) begin
          m = model(W, 128'(a), 128'(b), ci);
          q.push_back('{m[129:2], m[1], m[0], cyc, st});
        end
      end
      cyc++;
    end
    if (i > 0) begin : g_rnd
      initial begin
        wait (rst === 1'b0);
        for (int n = 0; n < 25000; n++) begin
          @(posedge clk);
          #1;
          in_valid = $urandom_range(0, 3) != 0;
          a = $urandom_range(0, 7) == 0 ? '1 : W'({$urandom(), $urandom(), $urandom(), $urandom()});
          b = $urandom_range(0, 7) == 0 ? {1'b0, {(W-1){1'b1}}} : W'({$urandom(), $urandom(), $urandom(), $urandom()});
          ci = 1'($urandom_range(0, 1));
          out_ready = $urandom_range(0, 3) != 0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (S + 3) @(posedge clk);
        done[i] = 1'b1;
      end
    end
  end
`ifdef CLA_ADD_PIPE_SAT_EN
  localparam logic [31:0] POS_OVF = 32'h7FFF_FFFF, NEG_OVF = 32'h8000_0000;
`else
  localparam logic [31:0] POS_OVF = 32'h8000_0000, NEG_OVF = 32'h0000_0000;
`endif
  task automatic vec(input string n, input logic [31:0] x, input logic [31:0] y, input logic c,
                     input logic [31:0] es, input logic eco, input logic eov);
    g_d[0].in_valid = 1'b1;
    g_d[0].a = x;
    g_d[0].b = y;
    g_d[0].ci = c;
    @(posedge clk);
    #1;
    g_d[0].in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({n, "_valid"}, g_d[0].out_valid, 1'b1);
    chk({n, "_s"}, g_d[0].s, es);
    chk({n, "_co"}, g_d[0].co, eco);
    chk({n, "_ovf"}, g_d[0].ovf, eov);
  endtask
  initial begin
    int cc, k;
    chk("model_carry", model(32, 128'h0000_FFFF, 128'h1, 1'b0), {128'h0001_0000, 2'b00});
    chk("model_wrap", model(32, 128'hFFFF_FFFF, 128'h0, 1'b1), {128'h0, 2'b10});
    @(posedge clk);
    #1;
    g_d[0].in_valid = 1'b1;
    g_d[0].a = 32'h1234;
    g_d[0].b = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    g_d[0].in_valid = 1'b0;
    chk("rst_out_valid", g_d[0].out_valid, 1'b0);
    chk("rst_s", g_d[0].s, 32'h0);
    chk("rst_co_ovf", {g_d[0].co, g_d[0].ovf}, 2'b00);
    chk("rst_in_ready", g_d[0].in_ready, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("beat_in_reset_dropped", g_d[0].out_valid, 1'b0);
    end
    vec("grp_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    vec("all_ones_ci", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    vec("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, POS_OVF, 1'b0, 1'b1);
    vec("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, NEG_OVF, 1'b1, 1'b1);
    vec("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0);
    cc = 0;
    k = 0;
    while (k < 8 && cc < 40) begin
      g_d[0].in_valid = 1'b1;
      g_d[0].a = 32'h1111_1111 * (k + 1);
      g_d[0].b = 32'hF000_FFF0 + k;
      g_d[0].ci = 1'(k);
      g_d[0].out_ready = !(cc >= 3 && cc < 7);
      @(negedge clk);
      if (cc >= 3 && cc < 7) chk("stall_in_ready", g_d[0].in_ready, 1'b0);
      if (g_d[0].in_ready) k++;
      @(posedge clk);
      #1;
      cc++;
    end
    chk("b2b_all_accepted", k, 8);
    g_d[0].in_valid = 1'b0;
    g_d[0].out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_drained", g_d[0].q.size(), 0);
    g_d[0].in_valid = 1'b1;
    g_d[0].a = 32'hDEAD_BEEF;
    g_d[0].b = 32'h1;
    @(posedge clk);
    #1;
    g_d[0].a = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    g_d[0].in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", g_d[0].out_valid, 1'b0);
    chk("midrst_s", g_d[0].s, 32'h0);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale", g_d[0].out_valid, 1'b0);
    end
    for (int t = 0; t < 60000 && done[2:1] != 2'b11; t++) @(posedge clk);
    chk("random_done", done[2:1], 2'b11);
    chk("drain1", g_d[1].q.size(), 0);
    chk("drain2", g_d[2].q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_add_pipe.md
CLA_ADD_PIPE -- requirements
Module: cla_add_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/sum width; legal 16..128, multiple of 16.
REQ-002 The block SHALL have parameter STAGES, default 2, pipeline register stages; legal 1..WIDTH/16.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  operand beat present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 The block SHALL have port a  input  WIDTH  operand A (two's complement when signed flags are read).
REQ-008 The block SHALL have port b  input  WIDTH  operand B.
REQ-009 The block SHALL have port ci  input  1  carry-in.
REQ-010 The block SHALL have port out_valid  output  1  result beat present.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 The block SHALL have port s  output  WIDTH  sum.
REQ-013 The block SHALL have port co  output  1  unsigned carry-out.
REQ-014 The block SHALL have port ovf  output  1  signed overflow flag.

Function
REQ-015 Arithmetic SHALL be built from 16-bit carry-lookahead groups (group P/G) with lookahead carry between groups; no ripple across group boundaries within a stage.
REQ-016 {co,s} SHALL equal a+b+ci modulo 2^(WIDTH+1); ovf SHALL be 1 iff a[MSB]==b[MSB] and the raw sum MSB differs from a[MSB].
REQ-017 Groups SHALL be split across STAGES in contiguous LSB-first slices, ceil(WIDTH/16/STAGES) groups per slice, last slice taking the remainder; the inter-slice carry and the not-yet-added upper operand bits SHALL be registered at each stage boundary.
REQ-018 Handshake: an input beat transfers when in_valid && in_ready; an output beat transfers when out_valid && out_ready.
REQ-019 stall = out_valid && !out_ready; in_ready SHALL equal !stall (combinational from out_ready); on stall every stage register SHALL hold its value.
REQ-020 Latency: with no stall, a beat accepted in cycle N SHALL appear on out_valid/s/co/ovf in cycle N+STAGES; throughput one beat per cycle.
REQ-021 Bubbles SHALL propagate unchanged (no collapse); a stage whose valid is 0 SHALL still advance when not stalled.
REQ-022 s/co/ovf SHALL remain stable while out_valid && !out_ready.
REQ-023 Beats SHALL leave in acceptance order; no beat is dropped or duplicated.
REQ-024 Simultaneous output transfer and input acceptance in the same cycle SHALL be legal and lossless.
REQ-025 Operand inputs SHALL be ignored when in_valid is 0 or in_ready is 0.

Reset
REQ-026 While rst is 1 at a clock edge, all stage valids, s, co and ovf SHALL be cleared to 0; in_ready SHALL read 1 in the cycle after reset.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight beats; no beat accepted before reset appears afterwards.
REQ-028 A beat presented in the same cycle as rst=1 SHALL NOT be accepted.

Configuration
REQ-029 Macro CLA_ADD_PIPE_SAT_EN SHALL select signed saturation of the final output.
REQ-030 With CLA_ADD_PIPE_SAT_EN defined: on ovf=1, s SHALL be 2^(WIDTH-1)-1 if a[MSB]==0, else -2^(WIDTH-1); ovf still reports the overflow; co unchanged.
REQ-031 Without CLA_ADD_PIPE_SAT_EN: s SHALL be the wrapped sum; no saturation logic present.

Verification
REQ-032 WIDTH=32, STAGES=2: a=0x0000FFFF, b=0x00000001, ci=0 -> 2 cycles later s=0x00010000, co=0, ovf=0 (carry crosses group/stage boundary).
REQ-033 WIDTH=32: a=0xFFFFFFFF, b=0, ci=1 -> s=0x00000000, co=1, ovf=0; a=0x7FFFFFFF, b=1, ci=0 -> ovf=1, s=0x80000000 (no SAT) / 0x7FFFFFFF (SAT).
REQ-034 Back-to-back 8 beats with out_ready held 0 from cycle 3 for 4 cycles -> in_ready=0 during stall, s held stable, all 8 sums emitted in order, none lost.
REQ-035 Reset asserted with 2 beats in flight -> out_valid=0, s=0 next cycle; no stale beat emerges after rst deasserts.
REQ-036 WIDTH=64, STAGES=3 and STAGES=1, 10k random beats with random in_valid/out_ready -> every output equals reference a+b+ci, latency exactly STAGES when unstalled.
